opl3_ram_write_arbiter: RTL and testbench

- Owns one mem_simple_dual_port instance and shares its single write port between two requesters.
  - Pipeline writeback port: fixed priority, never stalled.
  - Host register-write port: valid/ready handshake, buffered in a 2-entry FIFO.
- Also sequences the read port: registered one-cycle read with write-first bypass.
- Sits between the register-file decode and the operator state RAMs.

---
 rtl/opl3_ram_write_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_opl3_ram_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_ram_write_arbiter.sv
// opl3_ram_write_arbiter
//   Shares the single write port of one simple dual-port RAM between two requesters:
//     - the pipeline writeback port, which has fixed priority and is never stalled;
//     - the host register-write port, which uses a valid/ready handshake and is
//       buffered in a 2-entry FIFO.
//   The module also drives the RAM read port. Reads are registered, take one cycle,
//   and use write-first bypass.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   p_we/p_addr/p_data  pipeline write strobe, address and data
//   h_valid/h_ready     host write handshake
//   h_addr/h_data       host write address and data
//   h_pending           host FIFO occupancy (0..2)
//   rd_en/rd_addr       read request and address
//   rd_data/rd_valid    read result and its one-cycle-late valid strobe
//
// mem_simple_dual_port (defined first in this file)
//   One write port and one read port. RAM contents are never touched by reset.
//   With OUTPUT_DELAY=1 the read data is registered. A write and a read to the same
//   address in the same cycle return the newly written word.

module mem_simple_dual_port #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    DEPTH         = 256,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
   parameter int                    OUTPUT_DELAY  = 1,
   localparam int                   AW            = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wea,
   input  logic [AW-1:0]         addra,
   input  logic [DATA_WIDTH-1:0] dia,
   input  logic                  reb,
   input  logic [AW-1:0]         addrb,
   output logic [DATA_WIDTH-1:0] dob
);

   logic [DATA_WIDTH-1:0] ram [DEPTH] = '{default: DEFAULT_VALUE};

   always_ff @(posedge clk) begin
      if (wea) begin
         ram[addra] <= dia;
      end
   end

   if (OUTPUT_DELAY == 0) begin : g_comb_read
      assign dob = ram[addrb];
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] dob_q;
      logic [DATA_WIDTH-1:0] dob_d;

      // Write-first: a same-cycle write to the read address wins over the stored word.
      // When reb is low the output register holds its previous value.
      always_comb begin
         dob_d = dob_q;
         if (reb) begin
            dob_d = (wea && (addra == addrb)) ? dia : ram[addrb];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dob_q <= DEFAULT_VALUE;
         end else begin
            dob_q <= dob_d;
         end
      end

      assign dob = dob_q;
   end

endmodule

module opl3_ram_write_arbiter #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    DEPTH         = 256,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
   localparam int                   AW            = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p_we,
   input  logic [AW-1:0]         p_addr,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  h_valid,
   output logic                  h_ready,
   input  logic [AW-1:0]         h_addr,
   input  logic [DATA_WIDTH-1:0] h_data,
   output logic [1:0]            h_pending,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   logic [AW-1:0]         fifo_addr_q [2];
   logic [AW-1:0]         fifo_addr_d [2];
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [DATA_WIDTH-1:0] fifo_data_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  push;
   logic                  pop;
   logic                  ram_we;
   logic [AW-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;

   // h_ready depends only on registered occupancy and reset, never on h_valid.
   assign h_ready   = (count_q != 2'd2) && !reset;
   assign h_pending = count_q;
   assign rd_valid  = rd_valid_q;

   // The pipeline always wins the write port. The FIFO head commits only on idle
   // pipeline cycles. A push into an empty FIFO is not visible at the head until the
   // following cycle, so a host write needs at least two cycles to reach the RAM.
   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_valid_d  = rd_en;

      push = h_valid && h_ready;
      pop  = !p_we && (count_q != 2'd0);

      ram_we   = p_we || pop;
      ram_addr = p_we ? p_addr : fifo_addr_q[rd_ptr_q];
      ram_din  = p_we ? p_data : fifo_data_q[rd_ptr_q];

      if (push) begin
         fifo_addr_d[wr_ptr_q] = h_addr;
         fifo_data_d[wr_ptr_q] = h_data;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Reset discards any queued host writes and cancels any in-flight read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_addr_q <= '{default: '0};
         fifo_data_q <= '{default: '0};
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         rd_valid_q  <= 1'b0;
      end else begin
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   mem_simple_dual_port #(
      .DATA_WIDTH   (DATA_WIDTH),
      .DEPTH        (DEPTH),
      .DEFAULT_VALUE(DEFAULT_VALUE),
      .OUTPUT_DELAY (1)
   ) u_ram (
      .clk  (clk),
      .rst  (reset),
      .wea  (ram_we),
      .addra(ram_addr),
      .dia  (ram_din),
      .reb  (rd_en),
      .addrb(rd_addr),
      .dob  (rd_data)
   );

endmodule

// File: tb/tb_opl3_ram_write_arbiter.sv
// tb_opl3_ram_write_arbiter
//   Self-checking bench for opl3_ram_write_arbiter.
//   Each read pushes its expected word into a queue. A negedge monitor pops the queue
//   and compares whenever rd_valid is seen.

module tb_opl3_ram_write_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       p_we;
   logic [7:0] p_addr;
   logic [7:0] p_data;
   logic       h_valid;
   logic       h_ready;
   logic [7:0] h_addr;
   logic [7:0] h_data;
   logic [1:0] h_pending;
   logic       rd_en;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       rd_valid;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   opl3_ram_write_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .p_we     (p_we),
      .p_addr   (p_addr),
      .p_data   (p_data),
      .h_valid  (h_valid),
      .h_ready  (h_ready),
      .h_addr   (h_addr),
      .h_data   (h_data),
      .h_pending(h_pending),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   // Scoreboard side: every rd_valid must match the oldest expected read word.
   always @(negedge clk) begin
      if (!reset && rd_valid) begin
         total = total + 1;
         if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("[TB] FAIL rd_unexpected: rd_valid=1 with no read outstanding, rd_data=%h", rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               bad = bad + 1;
               $display("[TB] FAIL rd_data: got %h expected %h", rd_data, e);
            end
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_read(input logic [7:0] a, input logic [7:0] e);
      rd_en   = 1'b1;
      rd_addr = a;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      rd_en = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      step();
      total = total + 1;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("[TB] FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total = total + 4;
      if (h_ready !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL rst_h_ready_in_reset: got %b expected 0", h_ready); end
      if (h_pending !== 2'd0) begin bad = bad + 1; $display("[TB] FAIL rst_h_pending_in_reset: got %0d expected 0", h_pending); end
      if (rd_valid !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL rst_rd_valid_in_reset: got %b expected 0", rd_valid); end
      if (rd_data !== 8'h00) begin bad = bad + 1; $display("[TB] FAIL rst_rd_data_in_reset: got %h expected 00", rd_data); end
      reset = 1'b0;
      repeat (10) step();
      total = total + 4;
      if (h_ready !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL idle_h_ready: got %b expected 1", h_ready); end
      if (h_pending !== 2'd0) begin bad = bad + 1; $display("[TB] FAIL idle_h_pending: got %0d expected 0", h_pending); end
      if (rd_valid !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL idle_rd_valid: got %b expected 0", rd_valid); end
      if (rd_data !== 8'h00) begin bad = bad + 1; $display("[TB] FAIL idle_rd_data: got %h expected 00", rd_data); end
   endtask

   task automatic test_host_write();
      h_valid = 1'b1; h_addr = 8'h20; h_data = 8'hA5;
      step();
      h_valid = 1'b0;
      total = total + 1;
      if (h_pending !== 2'd1) begin bad = bad + 1; $display("[TB] FAIL host_pending_after_push: got %0d expected 1", h_pending); end
      step();
      total = total + 1;
      if (h_pending !== 2'd0) begin bad = bad + 1; $display("[TB] FAIL host_pending_after_commit: got %0d expected 0", h_pending); end
      start_read(8'h20, 8'hA5);
      step();
      drain();
   endtask

   task automatic test_contention();
      p_we = 1'b1; p_addr = 8'h10; p_data = 8'h11;
      h_valid = 1'b1; h_addr = 8'h10; h_data = 8'h22;
      step();
      h_addr = 8'h11; h_data = 8'h33;
      step();
      total = total + 2;
      if (h_pending !== 2'd2) begin bad = bad + 1; $display("[TB] FAIL cont_pending_full: got %0d expected 2", h_pending); end
      if (h_ready !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL cont_ready_full: got %b expected 0", h_ready); end
      h_addr = 8'h12; h_data = 8'h44;
      step();
      step();
      h_valid = 1'b0;
      total = total + 1;
      if (h_pending !== 2'd2) begin bad = bad + 1; $display("[TB] FAIL cont_pending_blocked: got %0d expected 2", h_pending); end
      p_we = 1'b0;
      step();
      total = total + 1;
      if (h_pending !== 2'd1) begin bad = bad + 1; $display("[TB] FAIL cont_pending_first_commit: got %0d expected 1", h_pending); end
      step();
      total = total + 1;
      if (h_pending !== 2'd0) begin bad = bad + 1; $display("[TB] FAIL cont_pending_second_commit: got %0d expected 0", h_pending); end
      start_read(8'h10, 8'h22); step();
      start_read(8'h11, 8'h33); step();
      start_read(8'h12, 8'h00); step();
      drain();
   endtask

   task automatic test_bypass();
      p_we = 1'b1; p_addr = 8'h40; p_data = 8'h5C;
      start_read(8'h40, 8'h5C); step();
      start_read(8'h41, 8'h00); step();
      p_we = 1'b0;
      drain();
      h_valid = 1'b1; h_addr = 8'h60; h_data = 8'h99;
      step();
      h_valid = 1'b0;
      start_read(8'h60, 8'h99); step();
      drain();
   endtask

   task automatic test_no_forward();
      p_we = 1'b1; p_addr = 8'h70; p_data = 8'h01;
      h_valid = 1'b1; h_addr = 8'h50; h_data = 8'h77;
      step();
      h_valid = 1'b0;
      start_read(8'h50, 8'h00); step();
      rd_en = 1'b0;
      p_we = 1'b0;
      step();
      start_read(8'h50, 8'h77); step();
      drain();
   endtask

   task automatic test_reset_mid();
      p_we = 1'b1; p_addr = 8'h71; p_data = 8'h02;
      h_valid = 1'b1; h_addr = 8'h80; h_data = 8'hAA;
      step();
      h_addr = 8'h81; h_data = 8'hBB;
      step();
      h_valid = 1'b0;
      total = total + 1;
      if (h_pending !== 2'd2) begin bad = bad + 1; $display("[TB] FAIL mid_pending_before: got %0d expected 2", h_pending); end
      p_we = 1'b0;
      rd_en = 1'b1; rd_addr = 8'h20;
      reset = 1'b1;
      #1;
      total = total + 2;
      if (h_pending !== 2'd0) begin bad = bad + 1; $display("[TB] FAIL mid_pending_in_reset: got %0d expected 0", h_pending); end
      if (h_ready !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL mid_ready_in_reset: got %b expected 0", h_ready); end
      step();
      reset = 1'b0;
      rd_en = 1'b0;
      step();
      total = total + 3;
      if (rd_valid !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL mid_rd_valid_after: got %b expected 0", rd_valid); end
      if (h_pending !== 2'd0) begin bad = bad + 1; $display("[TB] FAIL mid_pending_after: got %0d expected 0", h_pending); end
      if (h_ready !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL mid_ready_after: got %b expected 1", h_ready); end
      start_read(8'h80, 8'h00); step();
      start_read(8'h81, 8'h00); step();
      drain();
   endtask

   initial begin
      reset = 1'b1;
      p_we = 1'b0; p_addr = '0; p_data = '0;
      h_valid = 1'b0; h_addr = '0; h_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      test_reset();
      test_host_write();
      test_contention();
      test_bypass();
      test_no_forward();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
